// File: rtl/multi_clk_div_pkg.sv
`default_nettype none
//==============================================================================
// Package : multi_clk_div_pkg
// Brief   : Shared lock-FSM state encoding and ratio/phase clamp helpers.
// Rev     : 1.0  initial release
//==============================================================================
package multi_clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILTER = 2'd1,
        RUN    = 2'd2
    } lock_state_e;

    localparam logic [31:0] c_MIN_RATIO = 32'd2;

    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        return (ratio < c_MIN_RATIO) ? c_MIN_RATIO : ratio;
    endfunction

    // Phase beyond the last count of the period snaps to the last count.
    function automatic logic [31:0] clamp_phase(input logic [31:0] ratio,
                                                input logic [31:0] phase);
        logic [31:0] w_ratio_eff;
        w_ratio_eff = clamp_ratio(ratio);
        return (phase < w_ratio_eff) ? phase : w_ratio_eff - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
//==============================================================================
// Module : clk_div_channel
// Brief  : One divider channel: clamped shadow config, counter, clk_en/outclk.
// Rev    : 1.0  initial release
//==============================================================================
module clk_div_channel
    import multi_clk_div_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             realign,
    input  logic             load,
    input  logic [CNT_W-1:0] ratio,
    input  logic [CNT_W-1:0] phase,
    output logic             clk_en,
    output logic             outclk
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_ratio;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_clk_en;
    logic             r_outclk;

    logic [CNT_W-1:0] w_ratio_nxt;
    logic [CNT_W-1:0] w_phase_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_wrap;
    logic             w_clk_en_nxt;
    logic             w_outclk_nxt;

    // run/realign describe the cycle after the coming edge, so every output
    // register is loaded with the value matching the count it will sit beside.
    always_comb begin
        w_ratio_nxt = r_ratio;
        w_phase_nxt = r_phase;
        if (load) begin
            w_ratio_nxt = CNT_W'(clamp_ratio(32'(ratio)));
            w_phase_nxt = CNT_W'(clamp_phase(32'(ratio), 32'(phase)));
        end

        w_wrap = r_ratio - c_ONE;
        if (!run || !r_run || realign) begin
            w_cnt_nxt = w_phase_nxt;
        end else if (r_cnt >= w_wrap) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + c_ONE;
        end

        w_clk_en_nxt = run && !(load && r_run) && (w_cnt_nxt == (w_ratio_nxt - c_ONE));
        w_outclk_nxt = run && (w_cnt_nxt < (w_ratio_nxt >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ratio  <= CNT_W'(c_MIN_RATIO);
            r_phase  <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_clk_en <= 1'b0;
            r_outclk <= 1'b0;
        end else begin
            r_ratio  <= w_ratio_nxt;
            r_phase  <= w_phase_nxt;
            r_cnt    <= w_cnt_nxt;
            r_run    <= run;
            r_clk_en <= w_clk_en_nxt;
            r_outclk <= w_outclk_nxt;
        end
    end

    assign clk_en = r_clk_en;
    assign outclk = r_outclk;

endmodule
`default_nettype wire

// File: rtl/multi_clk_div.sv
`default_nettype none
//==============================================================================
// Module : multi_clk_div
// Brief  : Lock-qualified multi-channel clock-enable / strobe generator.
//          Optional loss counter output enabled by CLKDIV_LOSS_CNT_EN.
// Rev    : 1.0  initial release
//==============================================================================
module multi_clk_div
    import multi_clk_div_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int LOCK_CYC = 1024
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*CNT_W-1:0] div_ratio,
    input  logic [NUM_CH*CNT_W-1:0] phase,
    input  logic                    cfg_load,
    output logic                    locked,
    output logic [NUM_CH-1:0]       clk_en,
    output logic [NUM_CH-1:0]       outclk,
    output logic                    cfg_busy
`ifdef CLKDIV_LOSS_CNT_EN
    ,
    output logic [7:0]              loss_cnt
`endif
);

    localparam int c_FILT_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(LOCK_CYC - 1);
    localparam logic [c_FILT_W-1:0] c_FILT_ONE  = c_FILT_W'(1);

    logic [1:0]          r_sync;
    lock_state_e         r_state;
    logic [c_FILT_W-1:0] r_filt;
    logic                r_locked;
    logic                r_busy;

    logic                w_lk_s;
    lock_state_e         w_state_nxt;
    logic [c_FILT_W-1:0] w_filt_nxt;
    logic [c_FILT_W-1:0] w_filt_inc;
    logic                w_run_nxt;

    assign w_lk_s = r_sync[1];

    // The IDLE cycle that sees lk_s rise counts as the first qualified cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_filt_nxt  = r_filt;
        w_filt_inc  = r_filt + c_FILT_ONE;
        case (r_state)
            IDLE: begin
                w_filt_nxt = '0;
                if (w_lk_s) begin
                    w_state_nxt = (LOCK_CYC == 1) ? RUN : FILTER;
                end
            end
            FILTER: begin
                if (!w_lk_s) begin
                    w_state_nxt = IDLE;
                    w_filt_nxt  = '0;
                end else if (w_filt_inc == c_FILT_LAST) begin
                    w_state_nxt = RUN;
                    w_filt_nxt  = '0;
                end else begin
                    w_filt_nxt  = w_filt_inc;
                end
            end
            RUN: begin
                if (!w_lk_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_filt_nxt  = '0;
            end
        endcase
        w_run_nxt = (w_state_nxt == RUN);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b00;
            r_state  <= IDLE;
            r_filt   <= '0;
            r_locked <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], pll_locked};
            r_state  <= w_state_nxt;
            r_filt   <= w_filt_nxt;
            r_locked <= w_run_nxt;
            r_busy   <= cfg_load && (r_state == RUN) && w_run_nxt;
        end
    end

    assign locked   = r_locked;
    assign cfg_busy = r_busy;

`ifdef CLKDIV_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= 8'd0;
        end else if ((r_state == RUN) && !w_lk_s && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign loss_cnt = r_loss_cnt;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        clk_div_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (refclk),
            .rst_n   (rst_n),
            .run     (w_run_nxt),
            .realign (r_busy),
            .load    (cfg_load),
            .ratio   (div_ratio[gi*CNT_W +: CNT_W]),
            .phase   (phase[gi*CNT_W +: CNT_W]),
            .clk_en  (clk_en[gi]),
            .outclk  (outclk[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_clk_div.sv
`default_nettype none
//==============================================================================
// Module : tb_multi_clk_div
// Brief  : Directed self-checking bench for multi_clk_div (2 ch, 8-bit, 16 cyc).
// Rev    : 1.0  initial release
//==============================================================================
module tb_multi_clk_div;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 8;
    localparam int LOCK_CYC = 16;

    // Expected {clk_en[1], clk_en[0], outclk[1], outclk[0]} from the locked edge on.
    localparam logic [3:0] T1 [8]  = '{4'h9, 4'h3, 4'h0, 4'hC, 4'h3, 4'h1, 4'h8, 4'h6};
    localparam logic [3:0] T3 [6]  = '{4'h6, 4'h3, 4'h1, 4'h0, 4'h8, 4'h6};
    localparam logic [3:0] T4 [7]  = '{4'h9, 4'h6, 4'h3, 4'h6, 4'h1, 4'h4, 4'h9};
    localparam logic [3:0] T5 [11] = '{4'h2, 4'h8, 4'h6, 4'h9, 4'h3, 4'h9,
                                       4'h3, 4'h8, 4'h2, 4'h8, 4'h6};

    logic                    refclk = 1'b0;
    logic                    rst_n;
    logic                    pll_locked;
    logic [NUM_CH*CNT_W-1:0] div_ratio;
    logic [NUM_CH*CNT_W-1:0] phase;
    logic                    cfg_load;
    logic                    locked;
    logic [NUM_CH-1:0]       clk_en;
    logic [NUM_CH-1:0]       outclk;
    logic                    cfg_busy;
`ifdef CLKDIV_LOSS_CNT_EN
    logic [7:0]              loss_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 refclk = ~refclk;

    multi_clk_div #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .LOCK_CYC (LOCK_CYC)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .div_ratio  (div_ratio),
        .phase      (phase),
        .cfg_load   (cfg_load),
        .locked     (locked),
        .clk_en     (clk_en),
        .outclk     (outclk),
        .cfg_busy   (cfg_busy)
`ifdef CLKDIV_LOSS_CNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Leave RUN, load config while idle, then raise lock and check its latency.
    task automatic load_and_lock(input logic [15:0] r, input logic [15:0] p, input string tag);
        pll_locked = 1'b0;
        step(4);
        div_ratio = r;
        phase     = p;
        cfg_load  = 1'b1;
        step(1);
        cfg_load  = 1'b0;
        check({tag, " busy idle"}, 32'(cfg_busy), 0);
        pll_locked = 1'b1;
        step(17);
        check({tag, " pre-lock"}, 32'(locked), 0);
        step(1);
        check({tag, " lock"}, 32'(locked), 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        cfg_load   = 1'b0;
        div_ratio  = '0;
        phase      = '0;
        step(3);
        check("reset", 32'({locked, cfg_busy, clk_en, outclk}), 0);
`ifdef CLKDIV_LOSS_CNT_EN
        check("reset loss_cnt", 32'(loss_cnt), 0);
`endif
        rst_n = 1'b1;
        step(2);

        // ch0 R=4 P=0, ch1 R=3 P=2
        load_and_lock({8'd3, 8'd4}, {8'd2, 8'd0}, "t1");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1 cyc%0d", i), 32'({clk_en, outclk}), 32'(T1[i]));
            step(1);
        end

        pll_locked = 1'b0;
        step(2);
        check("loss edge k+1", 32'(locked), 1);
        step(1);
        check("loss edge k+2", 32'({locked, clk_en, outclk}), 0);
`ifdef CLKDIV_LOSS_CNT_EN
        check("loss_cnt", 32'(loss_cnt), 1);
`endif
        step(3);
        check("loss idle", 32'({locked, clk_en, outclk}), 0);

        // One-cycle dropout mid-filter restarts the qualification count.
        pll_locked = 1'b1;
        step(12);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(5);
        check("glitch nominal", 32'(locked), 0);
        step(12);
        check("glitch pre-lock", 32'(locked), 0);
        step(1);
        check("glitch relock", 32'(locked), 1);

        #3 rst_n = 1'b0;
        #1;
        check("async reset", 32'({locked, cfg_busy, clk_en, outclk}), 0);
`ifdef CLKDIV_LOSS_CNT_EN
        check("async reset loss_cnt", 32'(loss_cnt), 0);
`endif
        pll_locked = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);

        // ch0 R=5 P=4, ch1 R=5 P=0
        load_and_lock({8'd5, 8'd5}, {8'd0, 8'd4}, "t3");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3 cyc%0d", i), 32'({clk_en, outclk}), 32'(T3[i]));
            step(1);
        end

        // ch0 R=0 P=0, ch1 R=6 P=9
        load_and_lock({8'd6, 8'd0}, {8'd9, 8'd0}, "t4");
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t4 cyc%0d", i), 32'({clk_en, outclk}), 32'(T4[i]));
            step(1);
        end

        // Realign: both R=3 P=0, then ch0 -> R=8 P=5, ch1 -> R=2 P=0
        load_and_lock({8'd3, 8'd3}, {8'd0, 8'd0}, "t5");
        check("t5 cyc0", 32'({clk_en, outclk}), 'h3);
        step(1);
        check("t5 cyc1", 32'({clk_en, outclk}), 'h0);
        div_ratio = {8'd2, 8'd8};
        phase     = {8'd0, 8'd5};
        cfg_load  = 1'b1;
        step(1);
        cfg_load  = 1'b0;
        check("t5 busy", 32'({cfg_busy, clk_en}), 'h4);
        step(1);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t5 post cyc%0d", i), 32'({cfg_busy, clk_en, outclk}), 32'(T5[i]));
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
